divided_clock_meter: RTL
========================

// Module: divided_clock_meter
// PURPOSE
//  Measures a divided clock that has been brought back in from a pad or from a
//  clock-divide/select stage, and decodes its divide factor.
//  - Samples clk_div_in in the clk domain and times every toggle (both edges).
//  - Reports the half-period and the implied divide factor.
//  - Declares lock after a run of identical half-periods.
//  - Serves as the on-chip checker for clock divider outputs.
// PARAMETERS
//  CNT_W       8   width of half-period counter and of the reported values
//  LOCK_COUNT  4   consecutive identical half-periods required to assert locked (>=2)
// PORTS
//  clk          in   1      system clock; all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  enable       in   1      0 = hold in IDLE, clear outputs
//  clk_div_in   in   1      divided clock under test; asynchronous to clk
//  half_period  out  CNT_W  last measured half-period in clk cycles
//  div_factor   out  CNT_W  decoded factor = half_period-1
//  meas_valid   out  1      one-cycle pulse when half_period/div_factor update
//  locked       out  1      LOCK_COUNT consecutive equal half-periods seen
//  timeout      out  1      no toggle within 2^CNT_W-1 cycles; sticky until next edge
// BEHAVIOUR
//  Reset / outputs
//  - rst, or enable=0: state=IDLE; all outputs 0; counter=0; match count=0.
//    Takes effect on the next posedge, including mid-measurement.
//  Front end
//  - 2-flop synchronizer, then a registered previous-sample flop.
//  - edge = sync ^ prev.
//  - Input-to-edge latency: 3 clk cycles.
//  - Toggles spaced >=1 cycle, synchronous to clk, are all detected.
//  State machine
//  - IDLE -> ACQUIRE when enable=1.
//  - ACQUIRE: wait for first edge. On edge: counter=1 -> MEASURE. No output update.
//  - MEASURE: counter increments per cycle, saturating at 2^CNT_W-1.
//    On edge, in the same registered update:
//      half_period = counter; div_factor = counter-1;
//      meas_valid = 1 for exactly one cycle; counter reloads to 1.
//    Edge-to-edge spacing of N cycles yields half_period = N.
//  Lock and mismatch
//  - New value == previous half_period: match count increments, saturating at LOCK_COUNT.
//  - Otherwise: match count=1 and locked=0 (cleared with that meas_valid).
//  - locked=1 in the same cycle as the meas_valid that brings match count to LOCK_COUNT.
//  - Transition into LOCKED follows the same rule. LOCKED stays in MEASURE-style counting.
//  Timeout
//  - Counter reaches 2^CNT_W-1 with no edge: timeout=1, locked=0, match count=0.
//    State -> ACQUIRE; half_period/div_factor hold their last values.
//  - timeout clears on the next detected edge; that edge only restarts timing (no meas_valid).
//  Simultaneous events
//  - Edge on the saturation cycle: edge wins; it is a normal measurement, no timeout.
//  - rst/enable=0 override everything.
//  Arithmetic
//  - All unsigned CNT_W-bit. div_factor never underflows (half_period>=1).
// STRUCTURE
//  - Package clk_meter_pkg: state enum {IDLE, ACQUIRE, MEASURE, LOCKED}; default CNT_W/LOCK_COUNT localparams.
//  - Sub-module sync_edge_detect: 2-flop synchronizer + toggle detect, 1-bit edge out, rst-cleared.
//  - Top: FSM, counter, compare, match counter, output registers.
// TESTING
//  - rst held 5 cycles, clk_div_in toggling -> all outputs 0 throughout.
//    After release, first meas_valid follows the 2nd edge.
//  - Input toggling every 4 clk -> meas_valid every 4 cycles, half_period=4, div_factor=3.
//    locked=1 on the 4th meas_valid.
//  - Locked at 4, switch to toggle every 6 -> first new meas_valid: half_period=6, locked=0.
//    locked=1 again after 4 equal values.
//  - Input frozen for 300 cycles (CNT_W=8) -> timeout=1 at counter=255, locked=0, half_period holds.
//    Next edge clears timeout with no meas_valid.
//  - enable dropped mid-measurement for 1 cycle -> outputs 0 next cycle.
//    Re-acquires; first meas_valid after 2 further edges.
//  - Input toggling every clk -> half_period=1, div_factor=0, locked after 4 pulses.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the divided-clock meter.
package clk_meter_pkg;

    // Default half-period counter width and lock run length.
    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned LOCK_COUNT_DEF = 4;

    // LOCKED counts exactly like MEASURE; it only records that a lock run is in progress.
    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        MEASURE,
        LOCKED
    } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous divided clock into the clk domain through two flops
// and flags every toggle (rising or falling) of the synchronized level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic toggle
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two-stage synchronizer followed by a one-cycle-delayed copy for toggle detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Any difference between the synchronized level and its previous value is an edge.
    always_comb begin
        toggle = sync2 ^ prev;
    end

endmodule

// File: rtl/divided_clock_meter.sv
// Measures the half-period of a divided clock returned from a pad or divider
// stage, decodes its divide factor, and reports lock and timeout status.
module divided_clock_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clk_div_in,
    output logic [CNT_W-1:0] half_period,
    output logic [CNT_W-1:0] div_factor,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned      MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [MW-1:0]    M_ONE   = MW'(1);

    meter_state_e     state;
    meter_state_e     state_n;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_n;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_n;
    logic [MW-1:0]    match_inc;
    logic [CNT_W-1:0] hp_n;
    logic [CNT_W-1:0] df_n;
    logic             mv_n;
    logic             locked_n;
    logic             timeout_n;
    logic             div_toggle;

    sync_edge_detect u_sync_edge_detect (
        .clk    (clk),
        .rst    (rst),
        .din    (clk_div_in),
        .toggle (div_toggle)
    );

    // Register state, counter, match count and all outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            match_cnt   <= '0;
            half_period <= '0;
            div_factor  <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            counter     <= counter_n;
            match_cnt   <= match_n;
            half_period <= hp_n;
            div_factor  <= df_n;
            meas_valid  <= mv_n;
            locked      <= locked_n;
            timeout     <= timeout_n;
        end
    end

    // Next-state, measurement, lock tracking and timeout decisions.
    always_comb begin
        state_n   = state;
        counter_n = counter;
        match_n   = match_cnt;
        match_inc = M_ONE;
        hp_n      = half_period;
        df_n      = div_factor;
        mv_n      = 1'b0;
        locked_n  = locked;
        timeout_n = timeout;

        if (!enable) begin
            state_n   = IDLE;
            counter_n = '0;
            match_n   = '0;
            hp_n      = '0;
            df_n      = '0;
            locked_n  = 1'b0;
            timeout_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ACQUIRE;
                end

                ACQUIRE: begin
                    // The first edge only starts timing; a pending timeout clears here.
                    if (div_toggle) begin
                        counter_n = CNT_ONE;
                        timeout_n = 1'b0;
                        state_n   = MEASURE;
                    end
                end

                MEASURE, LOCKED: begin
                    // An edge on the saturation cycle is a normal measurement, not a timeout.
                    if (div_toggle) begin
                        if (counter == half_period) begin
                            match_inc = (match_cnt == LOCK_M) ? LOCK_M : match_cnt + M_ONE;
                        end else begin
                            match_inc = M_ONE;
                        end
                        hp_n      = counter;
                        df_n      = counter - CNT_ONE;
                        mv_n      = 1'b1;
                        counter_n = CNT_ONE;
                        match_n   = match_inc;
                        locked_n  = (match_inc == LOCK_M);
                        state_n   = (match_inc == LOCK_M) ? LOCKED : MEASURE;
                    end else if (counter == CNT_MAX) begin
                        timeout_n = 1'b1;
                        locked_n  = 1'b0;
                        match_n   = '0;
                        counter_n = '0;
                        state_n   = ACQUIRE;
                    end else begin
                        counter_n = counter + CNT_ONE;
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule
